// File: rtl/nano_pkg.sv
// Shared definitions for the Nano MIPS control path and the ula block:
// opcodes, ALU op codes, FSM encoding and the decoded control bundle.
package nano_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_NEG  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_BEQZ = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ULA_PASSA_A = 3'b000;
  localparam logic [2:0] ULA_SOMA    = 3'b001;
  localparam logic [2:0] ULA_AND     = 3'b010;
  localparam logic [2:0] ULA_OR      = 3'b011;
  localparam logic [2:0] ULA_SUB     = 3'b100;
  localparam logic [2:0] ULA_NEG     = 3'b101;
  localparam logic [2:0] ULA_NOT     = 3'b110;

  typedef enum logic [2:0] {
    BUSCA, DECODIFICA, EXECUTA, ESCRITA, PARADO
  } estado_t;

  typedef struct packed {
    logic [2:0] opUla;
    logic       selAImm;
    logic       selBImm;
    logic       escreve;  // writes rd in ESCRITA
    logic       salto;    // unconditional pc<=imm
    logic       desvio;   // pc<=imm when ula_zero
    logic       parar;
    logic       usaRs;    // port A reads rs instead of rd
    logic       ilegal;
  } ctrl_t;
endpackage

// File: rtl/decodificador.sv
// Combinational opcode decoder: maps the 4-bit opcode to the control bundle.
module decodificador
  import nano_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_NOP:  ;
      OP_MOV:  begin ctrl.opUla = ULA_PASSA_A; ctrl.usaRs = 1'b1; ctrl.escreve = 1'b1; end
      OP_ADD:  begin ctrl.opUla = ULA_SOMA;    ctrl.escreve = 1'b1; end
      OP_AND:  begin ctrl.opUla = ULA_AND;     ctrl.escreve = 1'b1; end
      OP_OR:   begin ctrl.opUla = ULA_OR;      ctrl.escreve = 1'b1; end
      OP_SUB:  begin ctrl.opUla = ULA_SUB;     ctrl.escreve = 1'b1; end
      OP_NEG:  begin ctrl.opUla = ULA_NEG;     ctrl.escreve = 1'b1; end
      OP_NOT:  begin ctrl.opUla = ULA_NOT;     ctrl.escreve = 1'b1; end
      OP_LDI:  begin ctrl.opUla = ULA_PASSA_A; ctrl.selAImm = 1'b1; ctrl.escreve = 1'b1; end
      OP_ADDI: begin ctrl.opUla = ULA_SOMA;    ctrl.selBImm = 1'b1; ctrl.escreve = 1'b1; end
      OP_JMP:  ctrl.salto = 1'b1;
      OP_BEQZ: begin ctrl.opUla = ULA_PASSA_A; ctrl.desvio = 1'b1; end
      OP_HALT: ctrl.parar = 1'b1;
      default: ctrl.ilegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: fetch handshake, decode, execute, write-back FSM
// plus the program counter for the Nano MIPS datapath.
module unidade_controle
  import nano_pkg::*;
#(
  parameter int                    PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]   PC_RESET = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         instr,
  input  logic                instr_valid,
  input  logic                ula_zero,
  output logic                instr_req,
  output logic [PC_WIDTH-1:0] pc,
  output logic [2:0]          op_ula,
  output logic                sel_a_imm,
  output logic                sel_b_imm,
  output logic [7:0]          imm,
  output logic [1:0]          reg_addr_a,
  output logic [1:0]          reg_addr_b,
  output logic [1:0]          reg_waddr,
  output logic                reg_we,
  output logic                halted,
  output logic                erro_instr
);
  estado_t     estado, prox;
  logic [15:0] ir;
  ctrl_t       ctrl;
  logic        escreveR, saltoR, desvioR;

  decodificador uDec (.opcode(ir[15:12]), .ctrl(ctrl));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= BUSCA;
    else     estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      BUSCA:      if (instr_valid) prox = DECODIFICA;
      DECODIFICA: prox = ctrl.ilegal ? BUSCA : (ctrl.parar ? PARADO : EXECUTA);
      EXECUTA:    prox = escreveR ? ESCRITA : BUSCA;
      ESCRITA:    prox = BUSCA;
      PARADO:     prox = PARADO;
      default:    prox = BUSCA;
    endcase
  end

  // Request is held low while rst is asserted so it first rises after release.
  always_comb begin
    instr_req  = (estado == BUSCA) && !rst;
    reg_we     = (estado == ESCRITA);
    halted     = (estado == PARADO);
    erro_instr = (estado == DECODIFICA) && ctrl.ilegal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= PC_RESET;
      ir         <= '0;
      op_ula     <= ULA_PASSA_A;
      sel_a_imm  <= 1'b0;
      sel_b_imm  <= 1'b0;
      imm        <= '0;
      reg_addr_a <= '0;
      reg_addr_b <= '0;
      reg_waddr  <= '0;
      escreveR   <= 1'b0;
      saltoR     <= 1'b0;
      desvioR    <= 1'b0;
    end else begin
      if (estado == BUSCA && instr_valid) begin
        ir <= instr;
        pc <= pc + PC_WIDTH'(1);
      end
      if (estado == DECODIFICA) begin
        op_ula     <= ctrl.opUla;
        sel_a_imm  <= ctrl.selAImm;
        sel_b_imm  <= ctrl.selBImm;
        imm        <= ir[7:0];
        reg_addr_a <= ctrl.usaRs ? ir[9:8] : ir[11:10];
        reg_addr_b <= ir[9:8];
        reg_waddr  <= ir[11:10];
        escreveR   <= ctrl.escreve;
        saltoR     <= ctrl.salto;
        desvioR    <= ctrl.desvio;
      end
      // Jump target overrides the increment done at fetch.
      if (estado == EXECUTA && (saltoR || (desvioR && ula_zero)))
        pc <= PC_WIDTH'(imm);
    end
  end
endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle with a per-instruction reference model.
module tb_unidade_controle;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid, ula_zero;
  logic        instr_req, reg_we, halted, erro_instr, sel_a_imm, sel_b_imm;
  logic [7:0]  pc, imm;
  logic [2:0]  op_ula;
  logic [1:0]  reg_addr_a, reg_addr_b, reg_waddr;

  int checks = 0;
  int errors = 0;
  logic [7:0] mPc;

  unidade_controle #(.PC_WIDTH(8), .PC_RESET(8'h00)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .ula_zero(ula_zero),
    .instr_req(instr_req), .pc(pc), .op_ula(op_ula), .sel_a_imm(sel_a_imm),
    .sel_b_imm(sel_b_imm), .imm(imm), .reg_addr_a(reg_addr_a), .reg_addr_b(reg_addr_b),
    .reg_waddr(reg_waddr), .reg_we(reg_we), .halted(halted), .erro_instr(erro_instr)
  );

  always #5 clk = ~clk;

  // Expected decode from the instruction table; ALU ops 2..7 map to codes 1..6.
  function automatic void modelo(input logic [15:0] ins, output logic [2:0] op,
                                 output logic sa, output logic sb, output logic we,
                                 output logic il, output logic [1:0] aA);
    int o = int'(ins[15:12]);
    op = 3'd0; sa = 0; sb = 0; we = 0; il = 0; aA = ins[11:10];
    if (o == 1) begin we = 1; aA = ins[9:8]; end
    else if (o >= 2 && o <= 7) begin op = 3'(o - 1); we = 1; end
    else if (o == 8) begin sa = 1; we = 1; end
    else if (o == 9) begin op = 3'd1; sb = 1; we = 1; end
    else if (o == 0 || o == 10 || o == 11 || o == 15) ;
    else il = 1;
  endfunction

  task automatic wait_req(input string nome);
    int t = 0;
    while (!instr_req && t < 30) begin @(negedge clk); t++; end
    checks++;
    if (instr_req !== 1'b1) begin
      errors++; $display("FAIL %s_req_timeout instr_req=%b exp 1", nome, instr_req);
    end
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic z, input string nome);
    logic [2:0] eOp; logic eSa, eSb, eWe, eIl; logic [1:0] eA;
    logic [18:0] eVec;
    modelo(ins, eOp, eSa, eSb, eWe, eIl, eA);
    eVec = {eOp, eSa, eSb, eA, ins[9:8], ins[11:10], ins[7:0]};
    wait_req(nome);
    instr = ins; instr_valid = 1'b1; ula_zero = ~z;
    @(negedge clk);
    instr_valid = 1'b0; instr = 16'($urandom);
    mPc = mPc + 8'd1;
    checks++;
    if (erro_instr !== eIl || reg_we !== 1'b0 || instr_req !== 1'b0) begin
      errors++; $display("FAIL %s_dec erro=%b we=%b req=%b exp erro=%b we=0 req=0",
                         nome, erro_instr, reg_we, instr_req, eIl);
    end
    if (eIl) begin
      @(negedge clk);
      checks++;
      if (instr_req !== 1'b1 || erro_instr !== 1'b0 || reg_we !== 1'b0 || pc !== mPc) begin
        errors++; $display("FAIL %s_ilegal req=%b erro=%b we=%b pc=%h exp req=1 erro=0 we=0 pc=%h",
                           nome, instr_req, erro_instr, reg_we, pc, mPc);
      end
      return;
    end
    @(negedge clk);
    ula_zero = z;
    checks++;
    if ({op_ula, sel_a_imm, sel_b_imm, reg_addr_a, reg_addr_b, reg_waddr, imm} !== eVec
        || reg_we !== 1'b0) begin
      errors++; $display("FAIL %s_exe ctrl=%h we=%b exp ctrl=%h we=0", nome,
        {op_ula, sel_a_imm, sel_b_imm, reg_addr_a, reg_addr_b, reg_waddr, imm}, reg_we, eVec);
    end
    if (ins[15:12] == 4'hA || (ins[15:12] == 4'hB && z)) mPc = ins[7:0];
    @(negedge clk);
    ula_zero = 1'($urandom);
    checks++;
    if (reg_we !== eWe || pc !== mPc || instr_req !== !eWe ||
        {op_ula, sel_a_imm, sel_b_imm, reg_addr_a, reg_addr_b, reg_waddr, imm} !== eVec) begin
      errors++; $display("FAIL %s_wb we=%b pc=%h req=%b ctrl=%h exp we=%b pc=%h req=%b ctrl=%h",
        nome, reg_we, pc, instr_req,
        {op_ula, sel_a_imm, sel_b_imm, reg_addr_a, reg_addr_b, reg_waddr, imm},
        eWe, mPc, !eWe, eVec);
    end
    if (eWe) begin
      @(negedge clk);
      checks++;
      if (reg_we !== 1'b0 || instr_req !== 1'b1) begin
        errors++; $display("FAIL %s_after_wb we=%b req=%b exp we=0 req=1", nome, reg_we, instr_req);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instr = '0; ula_zero = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({instr_req, reg_we, halted, erro_instr, pc, op_ula, sel_a_imm, sel_b_imm, imm,
         reg_addr_a, reg_addr_b, reg_waddr} !== '0) begin
      errors++; $display("FAIL reset_values req=%b we=%b halt=%b pc=%h op=%h imm=%h exp all 0",
                         instr_req, reg_we, halted, pc, op_ula, imm);
    end
    rst = 1'b0; #1;
    checks++;
    if (instr_req !== 1'b1) begin errors++; $display("FAIL reset_release req=%b exp 1", instr_req); end
    @(negedge clk);
    instr = 16'h2600; instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; #1;
    checks++;
    if (pc !== 8'h00 || reg_we !== 1'b0 || op_ula !== 3'b000) begin
      errors++; $display("FAIL reset_mid_exe pc=%h we=%b op=%h exp pc=00 we=0 op=0", pc, reg_we, op_ula);
    end
    @(negedge clk);
    checks++;
    if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_hold we=%b exp 0", reg_we); end
    rst = 1'b0; #1;
    checks++;
    if (instr_req !== 1'b1 || pc !== 8'h00) begin
      errors++; $display("FAIL reset_mid_release req=%b pc=%h exp req=1 pc=00", instr_req, pc);
    end
    mPc = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_add();  run_instr(16'h2600, 1'b0, "add"); endtask
  task automatic test_ldi();  run_instr(16'h8CA5, 1'b1, "ldi"); endtask

  task automatic test_beqz();
    run_instr(16'hB040, 1'b1, "beqz_taken");
    run_instr(16'hB040, 1'b0, "beqz_not_taken");
  endtask

  task automatic test_wrap_jmp();
    run_instr(16'hA5FF, 1'b0, "jmp_ff");
    run_instr(16'h0000, 1'b0, "nop_wrap");
    run_instr(16'hA010, 1'b1, "jmp_10");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [3:0] o;
      o = 4'($urandom_range(0, 14));
      run_instr({o, 12'($urandom)}, 1'($urandom), "rand");
    end
  endtask

  task automatic test_illegal_halt();
    run_instr(16'hC000, 1'b0, "ilegal_c000");
    wait_req("halt");
    instr = 16'hF000; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; mPc = mPc + 8'd1;
    checks++;
    if (erro_instr !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_dec erro=%b halted=%b exp 0 0", erro_instr, halted);
    end
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || instr_req !== 1'b0) begin
      errors++; $display("FAIL halt_enter halted=%b req=%b exp 1 0", halted, instr_req);
    end
    repeat (20) begin
      instr_valid = 1'($urandom); instr = 16'($urandom);
      @(negedge clk);
      checks++;
      if (instr_req !== 1'b0 || halted !== 1'b1 || reg_we !== 1'b0 || pc !== mPc) begin
        errors++; $display("FAIL halt_stay req=%b halted=%b we=%b pc=%h exp 0 1 0 %h",
                           instr_req, halted, reg_we, pc, mPc);
      end
    end
    instr_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldi();
    test_beqz();
    test_wrap_jmp();
    test_random();
    test_illegal_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
Multi-cycle control unit for the Nano MIPS datapath and the command-side counterpart of the ula block. It fetches a 16-bit instruction via a request/valid handshake, decodes it, and drives the 3-bit ALU op code, operand selects, register-file addresses and write enable. It also maintains the program counter. It sits between instruction memory and the ALU/register-file datapath.

Parameters:
PC_RESET, 8'h00, program counter value loaded on reset
PC_WIDTH, 8, program counter width (PC wraps modulo 2^PC_WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
instr  input  16  instruction word from instruction memory
instr_valid  input  1  instr is valid this cycle
ula_zero  input  1  ALU result == 8'h00 (from datapath)
instr_req  output  1  fetch request to instruction memory
pc  output  PC_WIDTH  current fetch address
op_ula  output  3  ALU op code (000 A, 001 A+B, 010 A&B, 011 A|B, 100 A-B, 101 -A, 110 ~A)
sel_a_imm  output  1  1: ALU portA = imm; 0: portA = reg[reg_addr_a]
sel_b_imm  output  1  1: ALU portB = imm; 0: portB = reg[reg_addr_b]
imm  output  8  immediate field instr[7:0]
reg_addr_a  output  2  register-file read address A
reg_addr_b  output  2  register-file read address B
reg_waddr  output  2  register-file write address (= rd)
reg_we  output  1  register-file write enable, one-cycle pulse
halted  output  1  high while in PARADO
erro_instr  output  1  one-cycle pulse on an illegal opcode

Behaviour:
- Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
- Opcodes and required actions:
  - 0000 NOP: no write.
  - 0001 MOV: op 000, addr_a=rs.
  - 0010 ADD: op 001. 0011 AND: op 010. 0100 OR: op 011. 0101 SUB: op 100.
  - 0110 NEG: op 101. 0111 NOT: op 110.
  - 1000 LDI: op 000, sel_a_imm=1. 1001 ADDI: op 001, sel_b_imm=1.
  - 1010 JMP: pc<=imm. 1011 BEQZ: op 000, addr_a=rd; if ula_zero then pc<=imm.
  - 1111 HALT. All other opcodes are illegal.
- Read addresses: default addr_a=rd, addr_b=rs. Only MOV uses addr_a=rs.
- Register writes: all ALU ops, MOV, LDI and ADDI write rd. NOP, JMP, BEQZ, HALT and illegal opcodes never assert reg_we.
- FSM states: BUSCA, DECODIFICA, EXECUTA, ESCRITA, PARADO.
- BUSCA:
  - instr_req=1 and held until instr_valid.
  - On instr_valid: latch IR, pc<=pc+1 (wraps 255->0), go to DECODIFICA.
  - instr_valid while instr_req=0 is ignored.
- DECODIFICA (1 cycle):
  - Register op_ula, selects, addresses and imm. These stay stable through ESCRITA.
  - Illegal opcode: pulse erro_instr, go to BUSCA (treated as NOP).
  - HALT: go to PARADO.
- EXECUTA (1 cycle):
  - ALU settles combinationally.
  - ula_zero is sampled only here, for BEQZ.
  - JMP or taken BEQZ loads pc<=imm, overriding the earlier increment.
  - Writing opcodes go to ESCRITA; all others go to BUSCA.
- ESCRITA (1 cycle): reg_we=1, then BUSCA.
- PARADO: all strobes 0, halted=1. Stays here until rst.
- Latency:
  - Writing instruction: 4 cycles from instr_valid acceptance to reg_we (inclusive).
  - Non-writing instruction: 3 cycles.
  - Next instr_req is asserted the cycle after ESCRITA (or after EXECUTA for non-writing instructions).
- Reset values (asynchronous): state=BUSCA, pc=PC_RESET, IR=0, op_ula=000, sel_a_imm=0, sel_b_imm=0, imm=0, all addresses 0, reg_we=0, halted=0, erro_instr=0. instr_req rises in the first cycle after rst deasserts.
- Reset mid-operation: any state aborts immediately. No reg_we pulse may occur on or after the reset edge.

Decomposition:
- Shared package nano_pkg holds:
  - opcode localparams (OP_NOP … OP_HALT);
  - ALU op codes ULA_PASSA_A, ULA_SOMA, ULA_AND, ULA_OR, ULA_SUB, ULA_NEG, ULA_NOT, shared with ula;
  - state encoding.
- One natural sub-module: decodificador. It is purely combinational, mapping opcode to {op_ula, sel_a_imm, sel_b_imm, escreve, salto, ilegal}. The FSM and PC stay in unidade_controle.

Test Plan:
- Reset: assert rst mid-EXECUTA -> pc=00, reg_we=0, instr_req=1 on the first cycle after release.
- ADD r1,r2 (instr 16'h2600) with instr_valid on cycle 1 -> op_ula=001, addr_a=1, addr_b=2, reg_we pulses exactly once, 4 cycles later, reg_waddr=1, pc=01.
- LDI r3,8'hA5 (16'h8CA5) -> sel_a_imm=1, imm=A5, op_ula=000, reg_we pulse with reg_waddr=3.
- BEQZ r0,8'h40 (16'hB040): with ula_zero=1 -> pc=40, no reg_we; repeat with ula_zero=0 -> pc=previous+1.
- PC wrap and JMP: pc=FF, fetch NOP -> pc=00. Then JMP 8'h10 -> pc=10.
- Illegal opcode 16'hC000 -> erro_instr pulses for one cycle, no reg_we. Then HALT 16'hF000 -> halted=1, instr_req stays 0 for 20 cycles despite instr_valid toggling.
